display_uart: RTL and testbench

- Peripheral sink for the CPU's OUT instruction: captures the byte the controller places on the shared 16-bit bus when it asserts dsp_in_en, queues it, and serialises it as 8N1 UART on a single tx pin.
- Sits on the CPU bus beside memory and the register file; it is the receiving end of the controller's display-output strobe.
- Provides busy and full status and a sticky overflow flag.

---
 rtl/display_pkg.sv | 14 +
 rtl/display_fifo.sv | 67 ++++++
 rtl/display_uart.sv | 145 ++++++++++++++
 tb/tb_display_uart.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the display UART: FSM states and UART frame constants.
package display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int unsigned UART_DATA_BITS   = 8;
   localparam int unsigned UART_DEFAULT_DIV = 16;

endpackage

// File: rtl/display_fifo.sv
// Character FIFO for the display UART. A push while full is dropped,
// even when a pop happens on the same edge. full/empty are registered.
module display_fifo
   import display_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = UART_DATA_BITS,
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;
   logic [CW-1:0]    count_nxt;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Next occupancy from the accepted push/pop pair.
   always_comb begin
      count_nxt = count;
      case ({push_ok, pop_ok})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   // Storage write; contents need no reset since pointers gate visibility.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally as DEPTH is a power of two; flags track post-edge count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

endmodule

// File: rtl/display_uart.sv
// Display output sink: captures in[7:0] on dsp_in_en, queues it and sends
// it as 8N1 UART on tx. Reports busy, full and a sticky overflow flag.
module display_uart
   import display_pkg::*;
#(
   parameter int unsigned CLK_DIV = UART_DEFAULT_DIV,
   parameter int unsigned DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] in,
   input  logic        dsp_in_en,
   input  logic        ovf_clr,
   output logic        tx,
   output logic        busy,
   output logic        full,
   output logic        overflow
);

   localparam int unsigned CW     = $clog2(DEPTH + 1);
   localparam int unsigned BW     = $clog2(UART_DATA_BITS);
   localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

   uart_state_t                state;
   logic [15:0]                baud;
   logic [BW-1:0]              bit_idx;
   logic [UART_DATA_BITS-1:0]  shift;

   logic                       fifo_pop;
   logic [UART_DATA_BITS-1:0]  fifo_dout;
   logic [CW-1:0]              fifo_count;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       drop;
   logic                       fifo_has_nxt;
   logic                       idle_nxt;
   logic                       unused_hi;

   assign unused_hi = ^in[15:8];

   display_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (dsp_in_en),
      .pop   (fifo_pop),
      .din   (in[7:0]),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign full = fifo_full;

   // Pop only from IDLE; a strobe while full loses its byte.
   always_comb begin
      fifo_pop = (state == IDLE) && !fifo_empty;
      drop     = dsp_in_en && fifo_full;
   end

   // Post-edge occupancy and FSM idleness, so busy can be registered
   // without a cycle of lag.
   always_comb begin
      fifo_has_nxt = (dsp_in_en && !fifo_full)
                  || (fifo_count > CW'(1))
                  || ((fifo_count == CW'(1)) && !fifo_pop);
      idle_nxt     = ((state == IDLE) && fifo_empty)
                  || ((state == STOP) && (baud == '0));
   end

   // Transmit FSM with baud counter, shift register, tx, busy and overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         baud     <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         busy <= fifo_has_nxt || !idle_nxt;

         if (drop) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end

         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (!fifo_empty) begin
                  shift <= fifo_dout;
                  baud  <= DIV_M1;
                  tx    <= 1'b0;
                  state <= START;
               end
            end
            START: begin
               if (baud == '0) begin
                  baud    <= DIV_M1;
                  bit_idx <= '0;
                  tx      <= shift[0];
                  state   <= DATA;
               end else begin
                  baud <= baud - 1'b1;
               end
            end
            DATA: begin
               if (baud == '0) begin
                  baud  <= DIV_M1;
                  shift <= {1'b0, shift[UART_DATA_BITS-1:1]};
                  if (bit_idx == LAST_BIT) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     tx      <= shift[1];
                  end
               end else begin
                  baud <= baud - 1'b1;
               end
            end
            STOP: begin
               tx <= 1'b1;
               if (baud == '0) begin
                  state <= IDLE;
               end else begin
                  baud <= baud - 1'b1;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_display_uart.sv
// Self-checking bench for display_uart: a queue-based FIFO/transmitter
// timing model plus a tx line decoder, driven by per-feature tasks.
module tb_display_uart;

   localparam int DIV   = 4;
   localparam int DEP   = 8;
   localparam int FRAME = 10 * DIV;

   logic        clk;
   logic        rst_n;
   logic [15:0] din;
   logic        en;
   logic        ovf_clr;
   logic        tx;
   logic        busy;
   logic        full;
   logic        overflow;

   int n_checks = 0;
   int n_errors = 0;

   display_uart #(
      .CLK_DIV (DIV),
      .DEPTH   (DEP)
   ) dut (
      .clk       (clk),
      .rst       (rst_n),
      .in        (din),
      .dsp_in_en (en),
      .ovf_clr   (ovf_clr),
      .tx        (tx),
      .busy      (busy),
      .full      (full),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // A pop happens on the first edge at which the transmitter is free and
   // data is queued; it then stays busy for one full frame.
   int         m_edge;
   int         m_idle_edge;
   int         m_cnt;
   logic       m_ovf;
   logic [7:0] m_fifo[$];
   logic [7:0] m_acc[$];
   logic       m_pop, m_push, m_drop;

   always_comb begin
      m_pop  = (m_edge >= m_idle_edge) && (m_cnt > 0);
      m_push = en && (m_cnt < DEP);
      m_drop = en && (m_cnt >= DEP);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_edge      <= 0;
         m_idle_edge <= 0;
         m_cnt       <= 0;
         m_ovf       <= 1'b0;
         m_fifo.delete();
      end else begin
         m_edge <= m_edge + 1;
         if (m_pop) begin
            m_acc.push_back(m_fifo.pop_front());
            m_idle_edge <= m_edge + 1 + FRAME;
         end
         if (m_push) m_fifo.push_back(din[7:0]);
         m_cnt <= m_cnt + int'(m_push) - int'(m_pop);
         if (m_drop) m_ovf <= 1'b1;
         else if (ovf_clr) m_ovf <= 1'b0;
      end
   end

   // ---------------- tx line decoder ----------------
   int         d_ph;
   int         d_gap;
   int         d_last_gap = 0;
   int         d_frame_err = 0;
   logic       d_active;
   logic [7:0] d_byte;
   logic [7:0] rx_q[$];

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_active <= 1'b0;
         d_ph     <= 0;
         d_gap    <= 0;
         d_byte   <= '0;
      end else if (!d_active) begin
         if (tx === 1'b0) begin
            d_active   <= 1'b1;
            d_ph       <= 1;
            d_last_gap <= d_gap;
            d_gap      <= 0;
         end else begin
            d_gap <= d_gap + 1;
         end
      end else begin
         d_ph <= d_ph + 1;
         if ((d_ph % DIV == DIV / 2) && (d_ph / DIV >= 1) && (d_ph / DIV <= 8))
            d_byte <= {tx, d_byte[7:1]};
         if (d_ph == 9 * DIV + DIV / 2) begin
            if (tx !== 1'b1) d_frame_err <= d_frame_err + 1;
            rx_q.push_back(d_byte);
         end
         if (d_ph == FRAME - 1) d_active <= 1'b0;
      end
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_hold: tx=%b busy=%b full=%b ovf=%b, required 1 0 0 0", tx, busy, full, overflow);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n_checks++;
         if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle cycle %0d: tx=%b busy=%b full=%b ovf=%b, required 1 0 0 0",
                     i, tx, busy, full, overflow);
         end
      end
   endtask

   task automatic test_single();
      logic [9:0] fr;
      rx_q.delete();
      m_acc.delete();
      fr = {1'b1, 8'h41, 1'b0};
      din = 16'hAB41;
      en  = 1'b1;
      @(negedge clk);
      en = 1'b0;
      din = 16'(($urandom & 32'hFF) << 8);
      n_checks++;
      if (tx !== 1'b1 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL single_accept: tx=%b busy=%b, required 1 1", tx, busy);
      end
      for (int j = 0; j < FRAME; j++) begin
         @(negedge clk);
         n_checks++;
         if (tx !== fr[j / DIV] || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL single_wave cycle %0d: tx=%b busy=%b, required %b 1", j, tx, busy, fr[j / DIV]);
         end
      end
      @(negedge clk);
      n_checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL single_done: tx=%b busy=%b, required 1 0", tx, busy);
      end
      n_checks++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'h41) begin
         n_errors++;
         $display("FAIL single_byte: got %0d bytes first=%h, required 1 byte 41",
                  rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] want[2];
      want[0] = 8'h55;
      want[1] = 8'hAA;
      rx_q.delete();
      m_acc.delete();
      for (int i = 0; i < 2; i++) begin
         din = {8'($urandom), want[i]};
         en  = 1'b1;
         @(negedge clk);
      end
      en = 1'b0;
      for (int k = 0; k < 4 * FRAME && rx_q.size() < 2; k++) @(negedge clk);
      n_checks++;
      if (rx_q.size() != 2) begin
         n_errors++;
         $display("FAIL b2b_count: got %0d bytes, required 2", rx_q.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (rx_q[i] !== want[i]) begin
               n_errors++;
               $display("FAIL b2b_byte%0d: got %h, required %h", i, rx_q[i], want[i]);
            end
         end
      end
      n_checks++;
      if (d_last_gap != 1) begin
         n_errors++;
         $display("FAIL b2b_gap: idle cycles between frames %0d, required 1", d_last_gap);
      end
      repeat (FRAME) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         n_errors++;
         $display("FAIL b2b_idle: busy=%b tx=%b, required 0 1", busy, tx);
      end
   endtask

   task automatic test_overflow();
      rx_q.delete();
      m_acc.delete();
      for (int i = 0; i < 10; i++) begin
         din = {8'($urandom), 8'(8'h30 + i)};
         en  = 1'b1;
         @(negedge clk);
         n_checks++;
         if (full !== (m_cnt == DEP) || overflow !== m_ovf || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_push%0d: full=%b ovf=%b busy=%b, required %b %b 1",
                     i, full, overflow, busy, (m_cnt == DEP), m_ovf);
         end
      end
      en = 1'b0;
      n_checks++;
      if (full !== 1'b1 || overflow !== 1'b1) begin
         n_errors++;
         $display("FAIL ovf_after_burst: full=%b ovf=%b, required 1 1", full, overflow);
      end
      for (int k = 0; k < 12 * FRAME && (busy === 1'b1 || rx_q.size() < 9); k++) begin
         @(negedge clk);
         n_checks++;
         if (full !== (m_cnt == DEP) || busy !== (m_cnt > 0 || m_edge < m_idle_edge)
             || overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_drain: full=%b busy=%b ovf=%b, required %b %b 1",
                     full, busy, overflow, (m_cnt == DEP), (m_cnt > 0 || m_edge < m_idle_edge));
         end
      end
      n_checks++;
      if (rx_q.size() != 9 || m_acc.size() != 9) begin
         n_errors++;
         $display("FAIL ovf_count: got %0d bytes (model %0d), required 9", rx_q.size(), m_acc.size());
      end else begin
         for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (rx_q[i] !== 8'(8'h30 + i) || rx_q[i] !== m_acc[i]) begin
               n_errors++;
               $display("FAIL ovf_byte%0d: got %h, required %h", i, rx_q[i], 8'(8'h30 + i));
            end
         end
      end
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      n_checks++;
      if (overflow !== 1'b0 || m_ovf !== 1'b0) begin
         n_errors++;
         $display("FAIL ovf_clear: ovf=%b, required 0", overflow);
      end
   endtask

   task automatic test_mid_reset();
      bit seen;
      rx_q.delete();
      m_acc.delete();
      for (int i = 0; i < 2; i++) begin
         din = 16'($urandom);
         en  = 1'b1;
         @(negedge clk);
      end
      en   = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 4 * FRAME && !seen; k++) begin
         @(negedge clk);
         if (d_active && d_ph == 4 * DIV + 1) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin
         n_errors++;
         $display("FAIL midrst_reach: data bit 3 not reached, required frame in progress");
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0) begin
         n_errors++;
         $display("FAIL midrst_async: tx=%b busy=%b full=%b, required 1 0 0", tx, busy, full);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         n_checks++;
         if (tx !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_after cycle %0d: tx=%b busy=%b, required 1 0", i, tx, busy);
         end
      end
      n_checks++;
      if (rx_q.size() != 0) begin
         n_errors++;
         $display("FAIL midrst_residual: got %0d bytes, required 0", rx_q.size());
      end
   endtask

   task automatic test_wrap();
      logic [7:0] sent[$];
      int         bound;
      rx_q.delete();
      m_acc.delete();
      for (int i = 0; i < 3 * DEP; i++) begin
         bound = 0;
         while (m_cnt >= DEP - 1 && bound < 2 * FRAME) begin
            @(negedge clk);
            bound++;
         end
         din = 16'($urandom);
         sent.push_back(din[7:0]);
         en = 1'b1;
         @(negedge clk);
         en = 1'b0;
         n_checks++;
         if (overflow !== 1'b0 || busy !== 1'b1 || full !== (m_cnt == DEP)) begin
            n_errors++;
            $display("FAIL wrap_push%0d: ovf=%b busy=%b full=%b, required 0 1 %b",
                     i, overflow, busy, full, (m_cnt == DEP));
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      for (int k = 0; k < 4 * DEP * FRAME && rx_q.size() < 3 * DEP; k++) @(negedge clk);
      n_checks++;
      if (rx_q.size() != 3 * DEP || m_acc.size() != 3 * DEP) begin
         n_errors++;
         $display("FAIL wrap_count: got %0d bytes (model %0d), required %0d",
                  rx_q.size(), m_acc.size(), 3 * DEP);
      end else begin
         for (int i = 0; i < 3 * DEP; i++) begin
            n_checks++;
            if (rx_q[i] !== sent[i] || m_acc[i] !== sent[i]) begin
               n_errors++;
               $display("FAIL wrap_byte%0d: got %h, required %h", i, rx_q[i], sent[i]);
            end
         end
      end
      n_checks++;
      if (overflow !== 1'b0) begin
         n_errors++;
         $display("FAIL wrap_ovf: ovf=%b, required 0", overflow);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      din     = '0;
      en      = 1'b0;
      ovf_clr = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_mid_reset();
      test_wrap();
      n_checks++;
      if (d_frame_err != 0) begin
         n_errors++;
         $display("FAIL stop_bits: %0d frames with low stop bit, required 0", d_frame_err);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
